// File: rtl/ifetch_buffer_pkg.sv
// Shared types and helpers for the instruction-fetch buffer: word width, instruction size,
// reset fetch address and the per-slot record held in the slot queue.
package ifetch_buffer_pkg;

  localparam int WORDSIZE   = 32;
  localparam int INST_BYTES = 4;

  typedef logic [WORDSIZE-1:0] word_t;

  localparam word_t PC_RESET = '0;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } slot_t;

  function automatic word_t incPc(input word_t pc);
    return pc + word_t'(INST_BYTES);
  endfunction

  function automatic word_t alignPc(input word_t pc);
    return pc & ~word_t'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/ifetch_buffer_slotq.sv
// Circular slot queue: slots are allocated at grant time, filled in request order as
// responses return, and popped from the head once filled.
module ifetch_buffer_slotq
  import ifetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          clear_i,
  input  logic          alloc_i,
  input  word_t         alloc_pc_i,
  input  logic          fill_i,
  input  word_t         fill_data_i,
  input  logic          pop_i,
  output logic          head_valid_o,
  output slot_t         head_o,
  output logic [PW-1:0] occupancy_o,
  output logic [PW-1:0] pending_o
);

  localparam int IW = PW - 1;

  slot_t         slots_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] fill_q;
  logic [PW-1:0] tail_q;

  // Pointers wrap naturally; the extra MSB separates full from empty.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
    end else if (clear_i) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
    end else begin
      if (alloc_i) begin
        slots_q[tail_q[IW-1:0]].pc <= alloc_pc_i;
        tail_q                     <= tail_q + PW'(1);
      end
      if (fill_i) begin
        slots_q[fill_q[IW-1:0]].inst <= fill_data_i;
        fill_q                       <= fill_q + PW'(1);
      end
      if (pop_i) begin
        head_q <= head_q + PW'(1);
      end
    end
  end

  always_comb begin
    head_valid_o = (head_q != fill_q);
    head_o       = slots_q[head_q[IW-1:0]];
    occupancy_o  = tail_q - head_q;
    pending_o    = tail_q - fill_q;
  end

  // A response arriving with no slot waiting for data is a memory protocol error.
  assert property (@(posedge clk_i) disable iff (!reset_ni)
                   (fill_i && !clear_i) |-> (fill_q != tail_q));

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch front end: owns the fetch PC, issues in-order word reads, buffers responses in the
// slot queue and hands {pc, instruction} to decode; redirects flush and drop stale responses.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = PC_RESET
) (
  input  logic  clk_i,
  input  logic  reset_ni,
  input  logic  redirect_i,
  input  word_t redirect_pc_i,
  output logic  mem_req_o,
  output word_t mem_addr_o,
  input  logic  mem_gnt_i,
  input  logic  mem_rvalid_i,
  input  word_t mem_rdata_i,
  output logic  inst_valid_o,
  input  logic  inst_ready_i,
  output word_t inst_pc_o,
  output word_t inst_out_o
);

  localparam int PW = $clog2(DEPTH) + 1;

  word_t         fpc_q, fpc_d;
  logic [PW-1:0] drop_q, drop_d;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] pending;
  logic          grant;
  logic          fillEn;
  logic          pop;
  logic          headValid;
  slot_t         head;

  // Issue uses registered occupancy, so a slot freed by a pop is reusable only next cycle.
  always_comb begin
    mem_req_o  = reset_ni && !redirect_i && (drop_q == '0) && (occupancy != PW'(DEPTH));
    mem_addr_o = fpc_q;
    grant      = mem_req_o && mem_gnt_i;
    fillEn     = mem_rvalid_i && (drop_q == '0) && !redirect_i;
    pop        = headValid && inst_ready_i && !redirect_i;

    fpc_d = fpc_q;
    if (redirect_i) begin
      fpc_d = alignPc(redirect_pc_i);
    end else if (grant) begin
      fpc_d = incPc(fpc_q);
    end

    // Every unreturned request at redirect time owes one response that must be discarded.
    drop_d = drop_q;
    if (redirect_i) begin
      drop_d = drop_q + pending - PW'(mem_rvalid_i);
    end else if (mem_rvalid_i && (drop_q != '0)) begin
      drop_d = drop_q - PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      fpc_q  <= RESET_PC;
      drop_q <= '0;
    end else begin
      fpc_q  <= fpc_d;
      drop_q <= drop_d;
    end
  end

  ifetch_buffer_slotq #(
    .DEPTH(DEPTH)
  ) u_slotq (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .clear_i     (redirect_i),
    .alloc_i     (grant),
    .alloc_pc_i  (fpc_q),
    .fill_i      (fillEn),
    .fill_data_i (mem_rdata_i),
    .pop_i       (pop),
    .head_valid_o(headValid),
    .head_o      (head),
    .occupancy_o (occupancy),
    .pending_o   (pending)
  );

  always_comb begin
    inst_valid_o = headValid;
    inst_pc_o    = head.pc;
    inst_out_o   = head.inst;
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: per-cycle vector table for streaming and backpressure,
// hand sequences for redirect, same-cycle redirect/pop/rvalid and fetch-address wrap.
module tb_ifetch_buffer;
  import ifetch_buffer_pkg::*;

  typedef struct {
    logic  rstn;
    logic  redir;
    word_t rpc;
    logic  gnt;
    logic  rv;
    word_t rdAddr;
    logic  rdy;
    logic  eReq;
    word_t eAddr;
    logic  eValid;
    word_t ePc;
  } vec_t;

  logic  clk = 1'b0;
  logic  rstn;
  logic  redirect;
  word_t redirectPc;
  logic  memReq;
  word_t memAddr;
  logic  memGnt;
  logic  memRvalid;
  word_t memRdata;
  logic  instValid;
  logic  instReady;
  word_t instPc;
  word_t instOut;

  logic  rstn2;
  logic  memReq2;
  word_t memAddr2;
  logic  memGnt2;
  logic  memRvalid2;
  word_t memRdata2;
  logic  instValid2;
  logic  instReady2;
  word_t instPc2;
  word_t instOut2;

  int    compared   = 0;
  int    mismatched = 0;
  vec_t  tbl[$];
  word_t wrapAddr[4];

  always #5 clk = ~clk;

  ifetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .reset_ni(rstn), .redirect_i(redirect), .redirect_pc_i(redirectPc),
    .mem_req_o(memReq), .mem_addr_o(memAddr), .mem_gnt_i(memGnt),
    .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata),
    .inst_valid_o(instValid), .inst_ready_i(instReady),
    .inst_pc_o(instPc), .inst_out_o(instOut)
  );

  ifetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk_i(clk), .reset_ni(rstn2), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .mem_req_o(memReq2), .mem_addr_o(memAddr2), .mem_gnt_i(memGnt2),
    .mem_rvalid_i(memRvalid2), .mem_rdata_i(memRdata2),
    .inst_valid_o(instValid2), .inst_ready_i(instReady2),
    .inst_pc_o(instPc2), .inst_out_o(instOut2)
  );

  function automatic word_t instOf(input word_t a);
    return a ^ 32'hC0DE_0013;
  endfunction

  // ctl = {rstn, redirect, gnt, rvalid, ready, expReq, expValid}
  function automatic vec_t mkVec(input logic [6:0] ctl, input word_t rpc, input word_t rdAddr,
                                 input word_t eAddr, input word_t ePc);
    vec_t v;
    v.rstn   = ctl[6];
    v.redir  = ctl[5];
    v.gnt    = ctl[4];
    v.rv     = ctl[3];
    v.rdy    = ctl[2];
    v.eReq   = ctl[1];
    v.eValid = ctl[0];
    v.rpc    = rpc;
    v.rdAddr = rdAddr;
    v.eAddr  = eAddr;
    v.ePc    = ePc;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input word_t actual, input word_t expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    @(negedge clk);
    rstn       = v.rstn;
    redirect   = v.redir;
    redirectPc = v.rpc;
    memGnt     = v.gnt;
    memRvalid  = v.rv;
    memRdata   = v.rv ? instOf(v.rdAddr) : 32'h0;
    instReady  = v.rdy;
    #2;
    checkOutput({tag, " mem_req"}, word_t'(memReq), word_t'(v.eReq));
    if (v.eReq) checkOutput({tag, " mem_addr"}, memAddr, v.eAddr);
    checkOutput({tag, " inst_valid"}, word_t'(instValid), word_t'(v.eValid));
    if (v.eValid) begin
      checkOutput({tag, " inst_pc"}, instPc, v.ePc);
      checkOutput({tag, " inst_out"}, instOut, instOf(v.ePc));
    end
  endtask

  initial begin
    rstn = 1'b0; redirect = 1'b0; redirectPc = '0; memGnt = 1'b0;
    memRvalid = 1'b0; memRdata = '0; instReady = 1'b0;
    rstn2 = 1'b0; memGnt2 = 1'b0; memRvalid2 = 1'b0; memRdata2 = '0; instReady2 = 1'b0;
    wrapAddr[0] = 32'hFFFF_FFF8; wrapAddr[1] = 32'hFFFF_FFFC;
    wrapAddr[2] = 32'h0000_0000; wrapAddr[3] = 32'h0000_0004;
    repeat (2) @(posedge clk);

    // Zero-wait memory, decode always ready: one instruction per cycle.
    tbl.push_back(mkVec(7'b0_0_0_0_1_0_0, 32'h0, 32'h0,  32'h0,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_0_1_1_0, 32'h0, 32'h0,  32'h0,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_1_1_1_0, 32'h0, 32'h0,  32'h4,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_1_1_1_1, 32'h0, 32'h4,  32'h8,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_1_1_1_1, 32'h0, 32'h8,  32'hC,  32'h4));
    tbl.push_back(mkVec(7'b1_0_1_1_1_1_1, 32'h0, 32'hC,  32'h10, 32'h8));
    tbl.push_back(mkVec(7'b1_0_0_1_1_1_1, 32'h0, 32'h10, 32'h14, 32'hC));
    tbl.push_back(mkVec(7'b1_0_0_0_1_1_1, 32'h0, 32'h0,  32'h14, 32'h10));
    tbl.push_back(mkVec(7'b1_0_0_0_1_1_0, 32'h0, 32'h0,  32'h14, 32'h0));
    // Backpressure: exactly four grants, then in-order drain and issue resumes at 0x10.
    tbl.push_back(mkVec(7'b0_0_0_0_0_0_0, 32'h0, 32'h0,  32'h0,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_0_0_1_0, 32'h0, 32'h0,  32'h0,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_1_0_1_0, 32'h0, 32'h0,  32'h4,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_1_0_1_1, 32'h0, 32'h4,  32'h8,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_1_0_1_1, 32'h0, 32'h8,  32'hC,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_1_0_0_1, 32'h0, 32'hC,  32'h0,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_0_0_0_1, 32'h0, 32'h0,  32'h0,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_0_1_0_1, 32'h0, 32'h0,  32'h0,  32'h0));
    tbl.push_back(mkVec(7'b1_0_1_0_1_1_1, 32'h0, 32'h0,  32'h10, 32'h4));
    tbl.push_back(mkVec(7'b1_0_0_1_1_1_1, 32'h0, 32'h10, 32'h14, 32'h8));
    tbl.push_back(mkVec(7'b1_0_0_0_1_1_1, 32'h0, 32'h0,  32'h14, 32'hC));
    tbl.push_back(mkVec(7'b1_0_0_0_1_1_1, 32'h0, 32'h0,  32'h14, 32'h10));
    // Grant withheld: request and address hold, then reset mid-stall.
    tbl.push_back(mkVec(7'b1_0_0_0_1_1_0, 32'h0, 32'h0,  32'h14, 32'h0));
    tbl.push_back(mkVec(7'b1_0_0_0_1_1_0, 32'h0, 32'h0,  32'h14, 32'h0));
    tbl.push_back(mkVec(7'b0_0_0_0_1_0_0, 32'h0, 32'h0,  32'h0,  32'h0));
    tbl.push_back(mkVec(7'b0_0_0_0_1_0_0, 32'h0, 32'h0,  32'h0,  32'h0));
    tbl.push_back(mkVec(7'b1_0_0_0_1_1_0, 32'h0, 32'h0,  32'h0,  32'h0));

    foreach (tbl[i]) applyStimulus($sformatf("vec%0d", i), tbl[i]);

    // Three-cycle latency, two requests in flight, redirect to an unaligned target.
    applyStimulus("redirA0",  mkVec(7'b0_0_0_0_1_0_0, 32'h0,   32'h0,   32'h0,   32'h0));
    applyStimulus("redirA1",  mkVec(7'b1_0_1_0_1_1_0, 32'h0,   32'h0,   32'h0,   32'h0));
    applyStimulus("redirA2",  mkVec(7'b1_0_1_0_1_1_0, 32'h0,   32'h0,   32'h4,   32'h0));
    applyStimulus("redirA3",  mkVec(7'b1_1_1_0_1_0_0, 32'h203, 32'h0,   32'h0,   32'h0));
    applyStimulus("redirA4",  mkVec(7'b1_0_1_1_1_0_0, 32'h0,   32'h0,   32'h0,   32'h0));
    applyStimulus("redirA5",  mkVec(7'b1_0_1_1_1_0_0, 32'h0,   32'h4,   32'h0,   32'h0));
    applyStimulus("redirA6",  mkVec(7'b1_0_1_0_1_1_0, 32'h0,   32'h0,   32'h200, 32'h0));
    applyStimulus("redirA7",  mkVec(7'b1_0_0_0_1_1_0, 32'h0,   32'h0,   32'h204, 32'h0));
    applyStimulus("redirA8",  mkVec(7'b1_0_0_0_1_1_0, 32'h0,   32'h0,   32'h204, 32'h0));
    applyStimulus("redirA9",  mkVec(7'b1_0_0_1_1_1_0, 32'h0,   32'h200, 32'h204, 32'h0));
    applyStimulus("redirA10", mkVec(7'b1_0_0_0_1_1_1, 32'h0,   32'h0,   32'h204, 32'h200));

    // Redirect, pop attempt and rvalid all in one cycle.
    applyStimulus("redirB0", mkVec(7'b0_0_0_0_0_0_0, 32'h0,  32'h0,  32'h0,  32'h0));
    applyStimulus("redirB1", mkVec(7'b1_0_1_0_0_1_0, 32'h0,  32'h0,  32'h0,  32'h0));
    applyStimulus("redirB2", mkVec(7'b1_0_1_1_0_1_0, 32'h0,  32'h0,  32'h4,  32'h0));
    applyStimulus("redirB3", mkVec(7'b1_0_0_0_0_1_1, 32'h0,  32'h0,  32'h8,  32'h0));
    applyStimulus("redirB4", mkVec(7'b1_1_1_1_1_0_1, 32'h40, 32'h4,  32'h0,  32'h0));
    applyStimulus("redirB5", mkVec(7'b1_0_0_0_1_1_0, 32'h0,  32'h0,  32'h40, 32'h0));
    applyStimulus("redirB6", mkVec(7'b1_0_1_0_1_1_0, 32'h0,  32'h0,  32'h40, 32'h0));
    applyStimulus("redirB7", mkVec(7'b1_0_0_1_1_1_0, 32'h0,  32'h40, 32'h44, 32'h0));
    applyStimulus("redirB8", mkVec(7'b1_0_0_0_1_1_1, 32'h0,  32'h0,  32'h44, 32'h40));
    applyStimulus("idle",    mkVec(7'b0_0_0_0_0_0_0, 32'h0,  32'h0,  32'h0,  32'h0));

    // Fetch address wraps past the top of the address space.
    @(negedge clk);
    memGnt2 = 1'b1;
    @(negedge clk);
    rstn2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      checkOutput($sformatf("wrap%0d mem_req", i), word_t'(memReq2), word_t'(i < 4));
      if (i < 4) checkOutput($sformatf("wrap%0d mem_addr", i), memAddr2, wrapAddr[i]);
      @(negedge clk);
    end
    memRvalid2 = 1'b1;
    memRdata2  = instOf(32'hFFFF_FFF8);
    @(negedge clk);
    memRvalid2 = 1'b0;
    #2;
    checkOutput("wrap inst_valid", word_t'(instValid2), 32'h1);
    checkOutput("wrap inst_pc", instPc2, 32'hFFFF_FFF8);
    checkOutput("wrap inst_out", instOut2, instOf(32'hFFFF_FFF8));
    @(negedge clk);
    rstn2 = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
